// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM stage: memory-op codes, FSM state encoding
// and small op-classification helpers used by the access unit and aligner.
// Optional feature macro used by this slice: BUS_TIMEOUT_EN.
package mem_access_unit_pkg;

  localparam int MEMOP_W = 4;

  typedef enum logic [MEMOP_W-1:0] {
    MEMOP_NONE = 4'd0,
    MEMOP_LW   = 4'd1,
    MEMOP_LH   = 4'd2,
    MEMOP_LHU  = 4'd3,
    MEMOP_LB   = 4'd4,
    MEMOP_LBU  = 4'd5,
    MEMOP_SW   = 4'd6,
    MEMOP_SH   = 4'd7,
    MEMOP_SB   = 4'd8
  } memop_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } mau_state_t;

  function automatic logic is_load_op(input logic [MEMOP_W-1:0] op);
    return (op == MEMOP_LW) || (op == MEMOP_LH) || (op == MEMOP_LHU) ||
           (op == MEMOP_LB) || (op == MEMOP_LBU);
  endfunction

  function automatic logic is_store_op(input logic [MEMOP_W-1:0] op);
    return (op == MEMOP_SW) || (op == MEMOP_SH) || (op == MEMOP_SB);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load aligner: picks the addressed byte/half of the bus read word and
// sign- or zero-extends it according to the load op. Purely combinational.
// LW and non-load ops pass the word through unchanged.
module mem_access_unit_load_align
  import mem_access_unit_pkg::*;
(
  input  logic [MEMOP_W-1:0] op,
  input  logic [1:0]         addr_lo,
  input  logic [31:0]        rdata,
  output logic [31:0]        result
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane select from the low address bits, then extend by op.
  always_comb begin
    sel_byte = rdata[8*addr_lo +: 8];
    sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result   = rdata;
    case (op)
      MEMOP_LB:  result = {{24{sel_byte[7]}}, sel_byte};
      MEMOP_LBU: result = {24'h0, sel_byte};
      MEMOP_LH:  result = {{16{sel_half[15]}}, sel_half};
      MEMOP_LHU: result = {16'h0, sel_half};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: turns the EX->MEM op into a req/ack data-bus access, aligns
// load data, loads the MEM->WB register and drives the MEM forward pair.
// stall is raised while an aligned access waits for ack. With BUS_TIMEOUT_EN
// defined, a WAIT lasting TIMEOUT_CYCLES stalled cycles is aborted.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MEMOP_W-1:0] mem_op_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  input  logic [31:0]        pc_i,
  input  logic [4:0]         reg_waddr_i,
  input  logic [31:0]        reg_wdata_i,
  output logic               bus_req_o,
  output logic               bus_we_o,
  output logic [31:0]        bus_addr_o,
  output logic [3:0]         bus_be_o,
  output logic [31:0]        bus_wdata_o,
  input  logic               bus_ack_i,
  input  logic [31:0]        bus_rdata_i,
  output logic               stall_o,
  output logic [4:0]         fwd_addr_o,
  output logic [31:0]        fwd_data_o,
  output logic               wb_valid_o,
  output logic [31:0]        wb_pc_o,
  output logic [4:0]         wb_waddr_o,
  output logic [31:0]        wb_wdata_o,
  output logic               addr_err_o,
  output logic               bus_err_o
);

  // The abort path compares against TIMEOUT_CYCLES-1, so it needs >= 2.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  mau_state_t  state;
  logic        is_mem;
  logic        is_load;
  logic        is_store;
  logic        misaligned;
  logic        abort;
  logic [31:0] load_word;

  assign is_mem   = (mem_op_i != MEMOP_NONE);
  assign is_load  = is_load_op(mem_op_i);
  assign is_store = is_store_op(mem_op_i);

  // Alignment check: words need addr[1:0]==0, halves need addr[0]==0.
  always_comb begin
    misaligned = 1'b0;
    case (mem_op_i)
      MEMOP_LW, MEMOP_SW:            misaligned = (addr_i[1:0] != 2'b00);
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: misaligned = addr_i[0];
      default:                       misaligned = 1'b0;
    endcase
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;

  // Entry cycle plus TIMEOUT_CYCLES-1 WAIT cycles have stalled; give up.
  assign abort = (state == S_WAIT) && !bus_ack_i && (wait_cnt == CNT_LAST);
`else
  assign abort = 1'b0;
`endif

  // Request is combinational so a same-cycle ack costs no stall; reset and
  // abort both drop it immediately.
  assign bus_req_o  = !reset && is_mem && !misaligned && !abort;
  assign stall_o    = bus_req_o && !bus_ack_i;
  assign bus_we_o   = bus_req_o && is_store;
  assign bus_addr_o = {addr_i[31:2], 2'b00};

  // Byte enables and store lane replication.
  always_comb begin
    bus_be_o    = 4'b0000;
    bus_wdata_o = wdata_i;
    case (mem_op_i)
      MEMOP_SB: begin
        bus_be_o    = 4'b0001 << addr_i[1:0];
        bus_wdata_o = {4{wdata_i[7:0]}};
      end
      MEMOP_SH: begin
        bus_be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
        bus_wdata_o = {2{wdata_i[15:0]}};
      end
      MEMOP_SW, MEMOP_LW, MEMOP_LH, MEMOP_LHU, MEMOP_LB, MEMOP_LBU:
        bus_be_o = 4'b1111;
      default: bus_be_o = 4'b0000;
    endcase
  end

  // Load data is not ready for forwarding until it reaches WB.
  assign fwd_addr_o = is_load ? 5'd0 : reg_waddr_i;
  assign fwd_data_o = reg_wdata_i;

  mem_access_unit_load_align u_load_align (
    .op      (mem_op_i),
    .addr_lo (addr_i[1:0]),
    .rdata   (bus_rdata_i),
    .result  (load_word)
  );

  // Bus FSM, timeout counter, error pulses and the MEM->WB register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wb_valid_o <= 1'b0;
      wb_pc_o    <= '0;
      wb_waddr_o <= '0;
      wb_wdata_o <= '0;
      addr_err_o <= 1'b0;
      bus_err_o  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      wait_cnt   <= '0;
`endif
    end else begin
      addr_err_o <= misaligned;
      bus_err_o  <= abort;

      case (state)
        S_IDLE: begin
          if (stall_o) begin
            state <= S_WAIT;
`ifdef BUS_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (bus_ack_i || abort) begin
            state <= S_IDLE;
          end
`ifdef BUS_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase

      if (!stall_o) begin
        wb_valid_o <= is_mem || (reg_waddr_i != 5'd0);
        wb_pc_o    <= pc_i;
        wb_waddr_o <= (misaligned || abort) ? 5'd0 : reg_waddr_i;
        wb_wdata_o <= is_load ? load_word : reg_wdata_i;
      end else begin
        wb_valid_o <= 1'b0;
        wb_waddr_o <= 5'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: bus handshake, stall length, lane
// selection and extension, misalignment, reset in WAIT and the WAIT
// limit (abort when BUS_TIMEOUT_EN is defined, indefinite wait otherwise).
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic [MEMOP_W-1:0] mem_op;
  logic [31:0]        addr, wdata, pc, reg_wdata, bus_addr, bus_wdata, bus_rdata;
  logic [4:0]         reg_waddr, fwd_addr, wb_waddr;
  logic               bus_req, bus_we, bus_ack, stall, wb_valid, addr_err, bus_err;
  logic [3:0]         bus_be;
  logic [31:0]        fwd_data, wb_pc, wb_wdata;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_op_i    (mem_op),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .pc_i        (pc),
    .reg_waddr_i (reg_waddr),
    .reg_wdata_i (reg_wdata),
    .bus_req_o   (bus_req),
    .bus_we_o    (bus_we),
    .bus_addr_o  (bus_addr),
    .bus_be_o    (bus_be),
    .bus_wdata_o (bus_wdata),
    .bus_ack_i   (bus_ack),
    .bus_rdata_i (bus_rdata),
    .stall_o     (stall),
    .fwd_addr_o  (fwd_addr),
    .fwd_data_o  (fwd_data),
    .wb_valid_o  (wb_valid),
    .wb_pc_o     (wb_pc),
    .wb_waddr_o  (wb_waddr),
    .wb_wdata_o  (wb_wdata),
    .addr_err_o  (addr_err),
    .bus_err_o   (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [MEMOP_W-1:0] op, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] wa,
                       input logic [31:0] rwd, input logic [31:0] p);
    mem_op = op; addr = a; wdata = wd; reg_waddr = wa; reg_wdata = rwd; pc = p;
  endtask

  // Load with the ack held off for three cycles, then delivered.
  task automatic delayed_load(input logic [MEMOP_W-1:0] op, input logic [31:0] exp, input string tag);
    drive(op, 32'h103, 32'h0, 5'd6, 32'h0, 32'h80);
    bus_rdata = 32'h80FF1234;
    bus_ack   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check({tag, " stall"}, stall, 1);
      if (i > 0) check({tag, " bubble"}, wb_valid, 0);
      tick();
    end
    bus_ack = 1'b1;
    #1;
    check({tag, " stall released"}, stall, 0);
    tick();
    bus_ack = 1'b0;
    drive(MEMOP_NONE, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    check({tag, " wb_wdata"}, wb_wdata, exp);
    check({tag, " wb_waddr"}, wb_waddr, 6);
    check({tag, " wb_valid"}, wb_valid, 1);
  endtask

  initial begin
    reset = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0;
    drive(MEMOP_NONE, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    tick(); tick();
    check("reset wb_valid", wb_valid, 0);
    check("reset wb_waddr", wb_waddr, 0);
    check("reset wb_wdata", wb_wdata, 0);
    check("reset wb_pc", wb_pc, 0);
    check("reset addr_err", addr_err, 0);
    check("reset bus_err", bus_err, 0);
    reset = 1'b0;

    // LW with same-cycle ack: no stall, data lands in WB next cycle.
    drive(MEMOP_LW, 32'h104, 32'h0, 5'd5, 32'h0, 32'h40);
    bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
    #1;
    check("lw req", bus_req, 1);
    check("lw addr", bus_addr, 32'h104);
    check("lw be", bus_be, 4'b1111);
    check("lw we", bus_we, 0);
    check("lw stall", stall, 0);
    check("lw fwd_addr", fwd_addr, 0);
    tick();
    bus_ack = 1'b0;
    drive(MEMOP_NONE, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    check("lw wb_wdata", wb_wdata, 32'hDEADBEEF);
    check("lw wb_valid", wb_valid, 1);
    check("lw wb_waddr", wb_waddr, 5);
    check("lw wb_pc", wb_pc, 32'h40);

    delayed_load(MEMOP_LB,  32'hFFFFFF80, "lb");
    delayed_load(MEMOP_LBU, 32'h00000080, "lbu");

    // Half store to upper lanes, then byte store to lane 1.
    drive(MEMOP_SH, 32'h202, 32'h0000ABCD, 5'd0, 32'h0, 32'h0);
    bus_ack = 1'b1;
    #1;
    check("sh be", bus_be, 4'b1100);
    check("sh wdata", bus_wdata, 32'hABCDABCD);
    check("sh we", bus_we, 1);
    check("sh addr", bus_addr, 32'h200);
    tick();
    drive(MEMOP_SB, 32'h201, 32'h0000005A, 5'd0, 32'h0, 32'h0);
    #1;
    check("sb be", bus_be, 4'b0010);
    check("sb wdata", bus_wdata, 32'h5A5A5A5A);
    check("sb stall", stall, 0);
    tick();
    bus_ack = 1'b0;
    drive(MEMOP_NONE, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    check("sb wb_valid", wb_valid, 1);

    // Misaligned LW: no request, error pulse, WB without destination.
    drive(MEMOP_LW, 32'h102, 32'h0, 5'd7, 32'h0, 32'h0);
    #1;
    check("mis req", bus_req, 0);
    check("mis stall", stall, 0);
    tick();
    drive(MEMOP_NONE, 32'h0, 32'h0, 5'd9, 32'h1234, 32'h0);
    check("mis addr_err", addr_err, 1);
    check("mis wb_waddr", wb_waddr, 0);
    check("mis wb_valid", wb_valid, 1);
    #1;
    check("alu fwd_addr", fwd_addr, 9);
    check("alu fwd_data", fwd_data, 32'h1234);
    tick();
    drive(MEMOP_NONE, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    check("mis addr_err clear", addr_err, 0);
    check("alu wb_waddr", wb_waddr, 9);
    check("alu wb_wdata", wb_wdata, 32'h1234);
    tick();
    check("nop wb_valid", wb_valid, 0);

    // Reset while waiting on the bus.
    drive(MEMOP_LW, 32'h300, 32'h0, 5'd3, 32'h0, 32'h60);
    tick();
    check("rst-wait stall", stall, 1);
    reset = 1'b1;
    #1;
    check("rst-wait req drop", bus_req, 0);
    tick();
    check("rst-wait wb_valid", wb_valid, 0);
    check("rst-wait wb_pc", wb_pc, 0);
    reset = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h11223344;
    #1;
    check("post-rst req", bus_req, 1);
    check("post-rst stall", stall, 0);
    tick();
    bus_ack = 1'b0;
    drive(MEMOP_NONE, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    check("post-rst wb_wdata", wb_wdata, 32'h11223344);
    check("post-rst wb_waddr", wb_waddr, 3);

    // Ack withheld.
    drive(MEMOP_LW, 32'h400, 32'h0, 5'd4, 32'h0, 32'h0);
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to stall", stall, 1);
      tick();
    end
    #1;
    check("to abort req", bus_req, 0);
    check("to abort stall", stall, 0);
    tick();
    drive(MEMOP_NONE, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    bus_ack = 1'b1;
    check("to bus_err", bus_err, 1);
    check("to wb_waddr", wb_waddr, 0);
    check("to wb_valid", wb_valid, 1);
    #1;
    check("to late ack req", bus_req, 0);
    check("to late ack stall", stall, 0);
    tick();
    bus_ack = 1'b0;
    check("to bus_err clear", bus_err, 0);
`else
    for (int i = 0; i < 8; i++) begin
      #1;
      check("wait stall", stall, 1);
      check("wait bus_err", bus_err, 0);
      tick();
    end
    bus_ack = 1'b1; bus_rdata = 32'h0BADF00D;
    #1;
    check("wait release", stall, 0);
    tick();
    bus_ack = 1'b0;
    drive(MEMOP_NONE, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0);
    check("wait wb_wdata", wb_wdata, 32'h0BADF00D);
    check("wait wb_waddr", wb_waddr, 4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
